// File: rtl/leds7_display_ctrl.sv
// leds7_display_ctrl: accepts a binary value over valid/ready, converts it to
// four BCD digits with a serial shift-add-3 engine, and drives four registered
// seven-segment indicators with leading-zero blanking and 9999 saturation.
module leds7_display_ctrl #(
  parameter int DATA_W        = 14,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
  output logic [6:0]        hex2,
  output logic [6:0]        hex3,
  output logic              overflow,
  output logic              busy
);

  localparam int         CNT_W     = $clog2(DATA_W + 1);
  localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_W-1:0]        bin_q;
  logic [15:0]              bcd_q;
  logic [15:0]              bcd_adj;
  logic [16+DATA_W-1:0]     shift_d;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_pend_q;
  logic                     accept;
  logic [3:0][6:0]          seg_d;
  logic                     lead_zero;
  logic [6:0]               raw;

  // abcdefg pattern (active-high) for one decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b0011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1110011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  assign accept = (state_q == IDLE) && in_valid && in_ready;

  // Next-state logic: IDLE -> CONVERT (DATA_W shifts) -> UPDATE -> IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(1)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on each nibble >= 5, then one left shift of {bcd, bin}.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shift_d = {bcd_adj, bin_q} << 1;
  end

  // Segment encoding with leading-zero blanking (hex0 always shown) and polarity.
  always_comb begin
    seg_d     = '0;
    lead_zero = 1'b1;
    raw       = 7'h00;
    for (int k = 3; k >= 0; k--) begin
      lead_zero = lead_zero && (bcd_q[4*k +: 4] == 4'd0);
      raw       = seg_of(bcd_q[4*k +: 4]);
      if (BLANK_LEADING && lead_zero && (k != 0)) raw = 7'h00;
      seg_d[k]  = ACTIVE_LOW ? ~raw : raw;
    end
  end

  // Control registers: state, registered handshake and busy flags.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == IDLE);
      busy     <= (state_d != IDLE);
    end
  end

  // Conversion datapath: latch/saturate on accept, shift during CONVERT.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: datapath registers are reset too, so an abandoned conversion leaves no residue.
    if (reset) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (32'(in_data) > 32'd9999) begin
              bin_q      <= DATA_W'(9999);
              ovf_pend_q <= 1'b1;
            end else begin
              bin_q      <= in_data;
              ovf_pend_q <= 1'b0;
            end
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= shift_d;
          cnt_q          <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Display registers: change only on the UPDATE edge, blank on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex0     <= SEG_BLANK;
      hex1     <= SEG_BLANK;
      hex2     <= SEG_BLANK;
      hex3     <= SEG_BLANK;
      overflow <= 1'b0;
    end else if (state_q == UPDATE) begin
      hex0     <= seg_d[0];
      hex1     <= seg_d[1];
      hex2     <= seg_d[2];
      hex3     <= seg_d[3];
      overflow <= ovf_pend_q;
    end
  end

endmodule

// File: tb/tb_leds7_display_ctrl.sv
// Scoreboard bench for leds7_display_ctrl: stimulus pushes decimal-model
// expectations at each accept; a monitor pops them when busy falls.
module tb_leds7_display_ctrl;

  localparam int DATA_W = 14;
  localparam int LAT    = DATA_W + 1;

  // abcdefg, active-high, digits 0..9
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011
  };

  typedef struct packed {
    logic [3:0][6:0] hb;   // expected with leading-zero blanking
    logic [3:0][6:0] hn;   // expected without blanking
    logic            ovf;
    logic [31:0]     acc_edge;
    logic [31:0]     val;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, busy, overflow;
  logic [6:0]        hex0, hex1, hex2, hex3;
  logic              in_ready_nb, busy_nb, overflow_nb;
  logic [6:0]        hex0_nb, hex1_nb, hex2_nb, hex3_nb;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  exp_t sb [$];

  leds7_display_ctrl #(.DATA_W(DATA_W), .BLANK_LEADING(1'b1), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .overflow(overflow), .busy(busy)
  );

  leds7_display_ctrl #(.DATA_W(DATA_W), .BLANK_LEADING(1'b0), .ACTIVE_LOW(1'b1)) dut_nb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
    .in_data(in_data), .hex0(hex0_nb), .hex1(hex1_nb), .hex2(hex2_nb), .hex3(hex3_nb),
    .overflow(overflow_nb), .busy(busy_nb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decimal reference: saturate, split into digits, blank digit k>0 when v < 10^k.
  function automatic exp_t model(input int val, input int acc);
    exp_t e;
    int   v;
    int   p;
    int   d;
    logic [6:0] r;
    v = (val > 9999) ? 9999 : val;
    p = 1;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      d       = (v / p) % 10;
      r       = SEG_TAB[d];
      e.hn[k] = ~r;
      e.hb[k] = ((k > 0) && (v < p)) ? 7'h7F : ~r;
      p       = p * 10;
    end
    e.ovf      = (val > 9999);
    e.acc_edge = acc;
    e.val      = val;
    return e;
  endfunction

  // Offer one value; expectation pushed once the accept edge is certain.
  task automatic send(input int v);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(v, edge_cnt + 1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: completion is the busy 1->0 transition; outputs must not move otherwise.
  logic [63:0] prev_out;
  logic        prev_busy = 1'b0;
  always @(negedge clk) begin
    logic [63:0] cur;
    exp_t e;
    cur = {hex3, hex2, hex1, hex0, overflow, hex3_nb, hex2_nb, hex1_nb, hex0_nb, overflow_nb, 6'd0};
    if (reset) begin
      prev_busy = 1'b0;
      prev_out  = cur;
    end else begin
      check("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
      check("nb_ready_match", {31'd0, in_ready_nb}, {31'd0, in_ready});
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          check("unexpected_update", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check($sformatf("latency v=%0d", e.val), edge_cnt, e.acc_edge + LAT);
          check($sformatf("hex0 v=%0d", e.val), {25'd0, hex0}, {25'd0, e.hb[0]});
          check($sformatf("hex1 v=%0d", e.val), {25'd0, hex1}, {25'd0, e.hb[1]});
          check($sformatf("hex2 v=%0d", e.val), {25'd0, hex2}, {25'd0, e.hb[2]});
          check($sformatf("hex3 v=%0d", e.val), {25'd0, hex3}, {25'd0, e.hb[3]});
          check($sformatf("ovf v=%0d", e.val), {31'd0, overflow}, {31'd0, e.ovf});
          check($sformatf("nb_hex v=%0d", e.val),
                {4'd0, hex3_nb, hex2_nb, hex1_nb, hex0_nb}, {4'd0, e.hn});
          check($sformatf("nb_ovf v=%0d", e.val), {31'd0, overflow_nb}, {31'd0, e.ovf});
        end
      end else if (cur != prev_out) begin
        check("output_glitch", cur[63:32] ^ prev_out[63:32] | cur[31:0] ^ prev_out[31:0], 32'd0);
      end
      prev_busy = busy;
      prev_out  = cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int last;
    int v;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'h7F}}});
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    #3 reset = 1'b0;
    #1 check("ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 check("ready_after_release", {31'd0, in_ready}, 32'd1);

    // Directed values and boundaries
    send(1234); drain();
    send(0);    drain();
    send(7);    drain();
    send(12000); drain();
    send(42);   drain();
    send(9999); send(10000); send(16383); send(1000); send(10); send(100);
    drain();

    // in_valid held high, data 5/6/7 changing every cycle
    last = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(5 + $urandom_range(2));
      if (in_ready) begin
        sb.push_back(model(int'(in_data), edge_cnt + 1));
        if (last >= 0) check("stream_spacing", edge_cnt + 1 - last, DATA_W + 2);
        last = edge_cnt + 1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Randomized values with random idle gaps
    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(3) == 0) ? int'($urandom_range(16383, 10000)) : int'($urandom_range(9999));
      send(v);
      repeat ($urandom_range(3)) @(negedge clk);
    end
    drain();

    // Reset five cycles into CONVERT abandons the conversion
    send(9999);
    repeat (4) @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_hex", {4'd0, hex3, hex2, hex1, hex0}, {4'd0, {4{7'h7F}}});
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    #3 reset = 1'b0;
    send(3);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leds7_display_ctrl.md
Name: leds7_display_ctrl

Overview:
Sequencer that accepts a binary value over a valid/ready handshake and converts it serially to four BCD digits with a shift-add-3 (double-dabble) engine. It then encodes each digit to abcdefg seven-segment code and drives the four board indicators LED0..LED3 (hex0..hex3), with leading-zero blanking and overflow saturation. It sits between application logic and the seven-segment pins, and is the single owner of the bin-to-segment encoding path.

Parameters:
DATA_W, 14, width of in_data; legal range 4..14.
BLANK_LEADING, 1, 1 = leading zero digits are blanked (all segments off); hex0 is never blanked.
ACTIVE_LOW, 1, 1 = segment outputs are inverted (board pins are active-low); 0 = active-high abcdefg.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  controller idle and able to accept
in_data  input  DATA_W  unsigned binary value to display
hex0  output  7  LED0 (units) segments, bit6 = a ... bit0 = g
hex1  output  7  LED1 (tens) segments
hex2  output  7  LED2 (hundreds) segments
hex3  output  7  LED3 (thousands) segments
overflow  output  1  last accepted value exceeded 9999
busy  output  1  conversion in progress (= ~in_ready outside reset)

Behaviour:
- Reset (async assert): state IDLE; hex0..hex3 = blank (7'h7F if ACTIVE_LOW, else 7'h00); overflow=0; busy=0; in_ready=0. in_ready is registered and rises on the first clk edge after reset deasserts.
- FSM states: IDLE -> CONVERT -> UPDATE -> IDLE.
- IDLE: in_ready=1. Accept occurs on an edge where in_valid && in_ready. On accept: latch in_data; if in_data > 9999, latch 9999 and set ovf_pend=1, else ovf_pend=0; clear the 16-bit BCD register and load the shift counter with DATA_W; go to CONVERT; in_ready=0 and busy=1 from that edge.
- CONVERT: one bin bit per cycle, exactly DATA_W cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd,bin} shifts left by 1 with the bin MSB entering bcd[0]. The counter decrements; on the last shift go to UPDATE. Adders are 4-bit per nibble, and no nibble may exceed 9 after the shift.
- UPDATE (1 cycle): encode each nibble with 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011. Apply blanking: when BLANK_LEADING=1, digit k (k=3..1) is blanked if it and all higher digits are 0. Invert if ACTIVE_LOW. Register hex0..hex3 and overflow<=ovf_pend on the UPDATE edge, then go to IDLE; in_ready=1 and busy=0 from that edge.
- Latency: accept at edge T; outputs change at edge T+DATA_W+1; in_ready high after edge T+DATA_W+1; next accept no earlier than edge T+DATA_W+2. Throughput is one value per DATA_W+2 cycles.
- Outputs hold their previous value during CONVERT, with no intermediate glitch values.
- in_valid/in_data are ignored outside IDLE. in_valid held high continuously yields back-to-back conversions at maximum rate.
- overflow updates only on UPDATE: it stays 1 until a later in-range value completes.
- Reset mid-CONVERT or mid-UPDATE: conversion is abandoned, outputs go blank immediately (async), and no partial value is ever displayed.
- Values with DATA_W < 14 cannot overflow; the compare is still legal.

Test Plan:
1. Reset asserted then released -> hex0..3 = 1111111, overflow=0, in_ready=0 during reset, in_ready=1 one edge after release.
2. Accept in_data=1234 (ACTIVE_LOW=1) -> exactly 15 edges later hex3=1001111, hex2=0010010, hex1=0000110, hex0=1001100; busy high for 15 cycles.
3. Accept 0 with BLANK_LEADING=1 -> hex3..hex1=1111111, hex0=0000001. Repeat with BLANK_LEADING=0 -> all four =0000001. Accept 7 -> hex0=0001111, others blank.
4. Accept 12000 -> all digits show 9 (0001100), overflow=1. Then accept 42 -> hex1=1001100, hex0=0010010, overflow=0 only after that UPDATE edge.
5. in_valid held high with data 5,6,7 changing every cycle -> accepts spaced exactly 16 edges apart, each display matches the value sampled at its accept edge, and intermediate data is ignored.
6. Accept 9999, then assert reset 5 cycles into CONVERT -> outputs blank immediately. After release, accept 3 -> display shows only 3 (hex0=0000110), with no residue of 9999.
